// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative 32x32 multiply / 32/32 divide unit for the EX stage.
// Runs MULTU, MULT, DIVU and DIV one bit per cycle over 32 cycles. It stalls
// the pipeline while it works, then gives a one-cycle HI/LO write.
//
// Ports:
//   clk       in   pipeline clock, rising edge
//   resetn    in   asynchronous active-low reset
//   start_i   in   EX holds a valid mul/div instruction
//   op_i      in   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   src1_i    in   rs value (multiplicand / dividend)
//   src2_i    in   rt value (multiplier / divisor)
//   cancel_i  in   flush; aborts any operation, beats start_i
//   stall_o   out  stall request to pipeline control
//   busy_o    out  operation in flight (RUN or DONE)
//   hi_we_o   out  HI write enable, one-cycle pulse
//   lo_we_o   out  LO write enable, one-cycle pulse
//   hi_o      out  product high word or remainder
//   lo_o      out  product low word or quotient
module hilo_muldiv (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic        cancel_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        hi_we_o,
  output logic        lo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [1:0]  r_op;
  logic        r_negRes;
  logic        r_negRem;
  logic        r_divZero;
  logic [31:0] r_src1;
  logic [31:0] r_opnd;
  logic [63:0] r_acc;

  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [32:0] w_mulSum;
  logic [32:0] w_trial;
  logic        w_qBit;
  logic [63:0] w_mulNext;
  logic [63:0] w_divNext;
  logic        w_signed;
  logic [63:0] w_product;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  // Signed ops work on magnitudes; the signs are fixed up in DONE.
  assign w_abs1 = (op_i[0] && src1_i[31]) ? -src1_i : src1_i;
  assign w_abs2 = (op_i[0] && src2_i[31]) ? -src2_i : src2_i;

  // Multiply: r_acc starts as {0, multiplier}. Each step adds the
  // multiplicand to the upper half when the current LSB is set, then shifts
  // the whole accumulator right. The multiplier bits drain out at the bottom.
  assign w_mulSum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mulNext = {w_mulSum, r_acc[31:1]};

  // Divide: r_acc holds {remainder, dividend/quotient}. r_acc[63:31] is the
  // remainder shifted left with the next dividend bit brought in. A
  // non-negative trial result is kept, and the quotient bit enters at the LSB.
  assign w_trial   = r_acc[63:31] - {1'b0, r_opnd};
  assign w_qBit    = ~w_trial[32];
  assign w_divNext = {(w_qBit ? w_trial[31:0] : r_acc[62:31]), r_acc[30:0], w_qBit};

  // Sign correction of the magnitude results for MULT/DIV.
  assign w_signed  = r_op[0];
  assign w_product = (w_signed && r_negRes) ? -r_acc : r_acc;
  assign w_quo     = (w_signed && r_negRes) ? -r_acc[31:0] : r_acc[31:0];
  assign w_rem     = (w_signed && r_negRem) ? -r_acc[63:32] : r_acc[63:32];

  // Control FSM and datapath registers. cancel_i always returns to IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_cnt     <= 5'd0;
      r_op      <= 2'd0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
      r_src1    <= 32'd0;
      r_opnd    <= 32'd0;
      r_acc     <= 64'd0;
    end else if (cancel_i) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state   <= S_RUN;
            r_cnt     <= 5'd0;
            r_op      <= op_i;
            r_negRes  <= src1_i[31] ^ src2_i[31];
            r_negRem  <= src1_i[31];
            r_divZero <= (src2_i == 32'd0);
            r_src1    <= src1_i;
            r_opnd    <= op_i[1] ? w_abs2 : w_abs1;
            r_acc     <= {32'd0, (op_i[1] ? w_abs1 : w_abs2)};
          end
        end
        S_RUN: begin
          r_acc <= r_op[1] ? w_divNext : w_mulNext;
          if (r_cnt == 5'd31) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode. Results appear only in DONE. A flush in that cycle
  // suppresses the write. stall_o must be combinational so that EX stalls
  // in the same cycle the instruction arrives.
  always_comb begin
    stall_o = resetn && (((r_state == S_IDLE) && start_i && !cancel_i) || (r_state == S_RUN));
    busy_o  = (r_state != S_IDLE);
    hi_we_o = 1'b0;
    lo_we_o = 1'b0;
    hi_o    = 32'd0;
    lo_o    = 32'd0;
    if (r_state == S_DONE) begin
      hi_we_o = !cancel_i;
      lo_we_o = !cancel_i;
      if (!r_op[1]) begin
        hi_o = w_product[63:32];
        lo_o = w_product[31:0];
      end else if (r_divZero) begin
        hi_o = r_src1;
        lo_o = 32'hFFFF_FFFF;
      end else begin
        hi_o = w_rem;
        lo_o = w_quo;
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: checks hilo_muldiv against a cycle-level behavioural model
// built from the HI/LO arithmetic rules and the 34-cycle occupancy timeline.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        cancel_i;
  logic        stall_o;
  logic        busy_o;
  logic        hi_we_o;
  logic        lo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int nChecks = 0;
  int nFails  = 0;

  // Model state: 0 = idle, 1..32 = iteration cycles, 33 = write cycle.
  int          mK = 0;
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;

  hilo_muldiv dut (
    .clk      (clk),
    .resetn   (resetn),
    .start_i  (start_i),
    .op_i     (op_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .cancel_i (cancel_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .hi_we_o  (hi_we_o),
    .lo_we_o  (lo_we_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // HI/LO arithmetic straight from the instruction definitions.
  function automatic void computeRef(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] up;
    longint sa, sb, p, q, r;
    int ia, ib;
    ia = a;
    ib = b;
    sa = ia;
    sb = ib;
    hi = 32'd0;
    lo = 32'd0;
    case (op)
      2'b00: begin
        up = {32'd0, a} * {32'd0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      2'b01: begin
        p  = sa * sb;
        hi = p[63:32];
        lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else if (op == 2'b10) begin
          hi = a % b;
          lo = a / b;
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          hi = r[31:0];
          lo = q[31:0];
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Advance the occupancy model on each edge from the inputs seen there.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mK = 0;
    end else if (cancel_i) begin
      mK = 0;
    end else if (mK == 0) begin
      if (start_i) begin
        mK = 1;
        computeRef(op_i, src1_i, src2_i, mHi, mLo);
      end
    end else if (mK == 33) begin
      mK = 0;
    end else begin
      mK++;
    end
  end

  // Compare every output on every cycle, mid-cycle.
  always @(negedge clk) begin
    logic eStall, eBusy, eWe;
    logic [31:0] eHi, eLo;
    eStall = 1'b0;
    eBusy  = 1'b0;
    eWe    = 1'b0;
    eHi    = 32'd0;
    eLo    = 32'd0;
    if (resetn) begin
      if (mK == 0) begin
        eStall = start_i && !cancel_i;
      end else if (mK <= 32) begin
        eStall = 1'b1;
        eBusy  = 1'b1;
      end else begin
        eBusy = 1'b1;
        eWe   = !cancel_i;
        eHi   = mHi;
        eLo   = mLo;
      end
    end
    checkVal("stall_o", 64'(stall_o), 64'(eStall));
    checkVal("busy_o", 64'(busy_o), 64'(eBusy));
    checkVal("hi_we_o", 64'(hi_we_o), 64'(eWe));
    checkVal("lo_we_o", 64'(lo_we_o), 64'(eWe));
    checkVal("hi_o", 64'(hi_o), 64'(eHi));
    checkVal("lo_o", 64'(lo_o), 64'(eLo));
  end

  // Present one instruction for a single cycle; caller sits just after an edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1;
    op_i    = op;
    src1_i  = a;
    src2_i  = b;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // Wait for the HI/LO write, check its values, latency and single-cycle width.
  task automatic checkOutput(input string name, input logic [31:0] expHi, input logic [31:0] expLo);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (hi_we_o) begin
        seen = 1'b1;
        lat  = i;
        checkVal({name, " hi"}, 64'(hi_o), 64'(expHi));
        checkVal({name, " lo"}, 64'(lo_o), 64'(expLo));
      end
    end
    checkVal({name, " latency"}, 64'(lat), 64'd33);
    @(negedge clk);
    checkVal({name, " we pulse width"}, 64'({hi_we_o, lo_we_o}), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rHi, rLo;
    int weCount;
    resetn   = 1'b0;
    start_i  = 1'b0;
    cancel_i = 1'b0;
    op_i     = 2'b00;
    src1_i   = 32'd0;
    src2_i   = 32'd0;

    // Pin the reference arithmetic with hand-computed values.
    computeRef(2'b01, 32'hFFFF_FFFD, 32'd5, rHi, rLo);
    checkVal("model mult -3*5", {rHi, rLo}, 64'hFFFF_FFFF_FFFF_FFF1);
    computeRef(2'b11, 32'hFFFF_FFF9, 32'd2, rHi, rLo);
    checkVal("model div -7/2", {rHi, rLo}, 64'hFFFF_FFFF_FFFF_FFFD);
    computeRef(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, rHi, rLo);
    checkVal("model div min/-1", {rHi, rLo}, 64'h0000_0000_8000_0000);

    repeat (2) @(posedge clk);
    #1;
    checkVal("reset outputs", {28'd0, stall_o, busy_o, hi_we_o, lo_we_o, hi_o, lo_o}, 64'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed operations");
    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("multu max", 32'hFFFF_FFFE, 32'h0000_0001);
    applyStimulus(2'b01, 32'hFFFF_FFFD, 32'd5);
    checkOutput("mult -3*5", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    applyStimulus(2'b11, 32'hFFFF_FFF9, 32'd2);
    checkOutput("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("div min/-1", 32'h0000_0000, 32'h8000_0000);
    applyStimulus(2'b10, 32'd100, 32'd0);
    checkOutput("divu 100/0", 32'h0000_0064, 32'hFFFF_FFFF);
    applyStimulus(2'b11, 32'hFFFF_FF9C, 32'd0);
    checkOutput("div -100/0", 32'hFFFF_FF9C, 32'hFFFF_FFFF);

    $display("[TB] cancel mid-operation");
    applyStimulus(2'b00, 32'd123, 32'd456);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    cancel_i = 1'b1;
    @(posedge clk);
    #1;
    cancel_i = 1'b0;
    checkVal("cancel stall", 64'(stall_o), 64'd0);
    checkVal("cancel busy", 64'(busy_o), 64'd0);
    applyStimulus(2'b00, 32'd6, 32'd7);
    checkOutput("multu after cancel", 32'd0, 32'd42);

    $display("[TB] reset mid-operation");
    applyStimulus(2'b11, 32'hFFFF_FF00, 32'd7);
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    #2;
    resetn = 1'b0;
    #1;
    checkVal("async reset outputs", {28'd0, stall_o, busy_o, hi_we_o, lo_we_o, hi_o, lo_o}, 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    weCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hi_we_o || lo_we_o) weCount++;
    end
    checkVal("no write after reset", 64'(weCount), 64'd0);
    @(posedge clk);
    #1;

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      start_i  = ($urandom_range(0, 3) == 0);
      op_i     = 2'($urandom_range(0, 3));
      src1_i   = pick();
      src2_i   = pick();
      cancel_i = ($urandom_range(0, 149) == 0);
      @(posedge clk);
      #1;
    end
    start_i  = 1'b0;
    cancel_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
